// File: rtl/ram_bank_arb.sv
// ram_bank_arb -- two-port arbiter in front of a single-ported RAM bank.
//
// Each cycle at most one of the two requesters is issued to the RAM. The
// grant pulse and the RAM controls register together at the same edge. A
// port that is granted is masked for the following cycle, so a request
// that is still held is not counted twice. Read data comes back one cycle
// after ram_re and is steered to the port that issued the read.
//
// Optional build macro:
//   RAM_ARB_FIXED_PRIO_EN  port 0 always wins contention (port 1 may starve).
//                          When it is undefined, contention is round-robin.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   req_i[p], we_i[p]     access request and write flag for port p
//   addr_i[p], wdata_i[p] access address and write data for port p
//   gnt_o[p]              one-cycle pulse: access issued to RAM this cycle
//   rvalid_o[p]           one-cycle pulse: rdata_o carries port p's result
//   rdata_o               shared read data
//   ram_en/we/re          registered RAM controls (we and re are exclusive)
//   ram_addr_w/r, ram_d_w registered RAM write/read address and write data
//   ram_d_r               RAM read data, valid the cycle after ram_re
module ram_bank_arb #(
  parameter int ADDR_BIT = 3,
  parameter int DATA_BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_i,
  input  logic [1:0]               we_i,
  input  logic [1:0][ADDR_BIT-1:0] addr_i,
  input  logic [1:0][DATA_BIT-1:0] wdata_i,
  output logic [1:0]               gnt_o,
  output logic [1:0]               rvalid_o,
  output logic [DATA_BIT-1:0]      rdata_o,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic                     ram_re,
  output logic [ADDR_BIT-1:0]      ram_addr_w,
  output logic [ADDR_BIT-1:0]      ram_addr_r,
  output logic [DATA_BIT-1:0]      ram_d_w,
  input  logic [DATA_BIT-1:0]      ram_d_r
);

  logic [1:0] elig;
  logic       any;
  logic       win;       // index of the winning port this cycle
  logic       rd_owner;  // port that owns the read currently on ram_re

  // A port granted last cycle is still holding req; skip it once.
  assign elig = req_i & ~gnt_o;
  assign any  = |elig;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it is eligible.
  assign win = ~elig[0];
`else
  logic last_gnt;

  // Contention goes to the port that did not win last; otherwise the lone
  // eligible port wins.
  always_comb begin
    win = elig[1];
    if (&elig) win = ~last_gnt;
  end

  // Reset value 1 hands port 0 the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_gnt <= 1'b1;
    else if (any) last_gnt <= win;
  end
`endif

  // Issue stage: grant pulse and RAM controls register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_o      <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr_w <= '0;
      ram_addr_r <= '0;
      ram_d_w    <= '0;
      rd_owner   <= 1'b0;
    end else if (any) begin
      gnt_o  <= win ? 2'b10 : 2'b01;
      ram_en <= 1'b1;
      ram_we <= we_i[win];
      ram_re <= ~we_i[win];
      if (we_i[win]) begin
        ram_addr_w <= addr_i[win];
        ram_d_w    <= wdata_i[win];
      end else begin
        ram_addr_r <= addr_i[win];
        rd_owner   <= win;
      end
    end else begin
      // Addresses and write data hold while idle.
      gnt_o  <= '0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_re <= 1'b0;
    end
  end

  // Return stage: the RAM answers the cycle after ram_re, so the owner tag
  // simply follows ram_re by one register. Reset drops an in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rvalid_o <= '0;
    else if (ram_re) rvalid_o <= rd_owner ? 2'b10 : 2'b01;
    else             rvalid_o <= '0;
  end

  // ram_d_r is only meaningful while a return is in flight; gate it so the
  // shared bus reads zero otherwise, including during reset.
  assign rdata_o = (|rvalid_o) ? ram_d_r : '0;

endmodule

// File: doc/ram_bank_arb.md
RAM_BANK_ARB -- requirements
Module: ram_bank_arb

Interface
REQ-001 Parameter ADDR_BIT, default 3, RAM address width.
REQ-002 Parameter DATA_BIT, default 16, RAM data width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_i[p] (p=0,1)  input  1 each  requester p asserts an access; held until gnt_o[p].
REQ-006 we_i[p]  input  1 each  1 = write, 0 = read; qualified by req_i[p].
REQ-007 addr_i[p]  input  ADDR_BIT each  access address.
REQ-008 wdata_i[p]  input  DATA_BIT each  write data.
REQ-009 gnt_o[p]  output  1 each  one-cycle pulse: access accepted, issued to RAM this cycle.
REQ-010 rvalid_o[p]  output  1 each  one-cycle pulse: rdata_o holds read result for p.
REQ-011 rdata_o  output  DATA_BIT  read data, shared by both requesters.
REQ-012 ram_en, ram_we, ram_re  output  1 each  RAM bank controls, registered.
REQ-013 ram_addr_w, ram_addr_r  output  ADDR_BIT each  RAM write/read addresses, registered.
REQ-014 ram_d_w  output  DATA_BIT  RAM write data, registered.
REQ-015 ram_d_r  input  DATA_BIT  RAM read data, valid one cycle after ram_re is sampled.

Function
REQ-016 At most one RAM operation per cycle; ram_we and ram_re SHALL never be 1 together.
REQ-017 Cycle N: eligible requests sampled, one winner picked; at edge ending N, RAM controls and gnt_o[winner] register; cycle N+1 shows both.
REQ-018 Port is eligible when req_i[p]=1 and gnt_o[p]=0 (a port just granted is masked for one cycle, so a held req is not double-counted).
REQ-019 Round-robin: pointer last_gnt toggles to winner on every grant; on contention, port != last_gnt wins.
REQ-020 Single eligible request always wins, regardless of pointer.
REQ-021 No eligible request: ram_en=0, ram_we=0, ram_re=0; addresses/data hold previous values.
REQ-022 Write grant: ram_en=1, ram_we=1, ram_addr_w=addr_i[p], ram_d_w=wdata_i[p].
REQ-023 Read grant: ram_en=1, ram_re=1, ram_addr_r=addr_i[p]; owner tag registered with it.
REQ-024 Read result: cycle after ram_re=1, rvalid_o[owner]=1 and rdata_o=ram_d_r; latency req-sample to rvalid = 2 cycles.
REQ-025 Back-to-back reads from alternating ports SHALL yield rvalid every cycle, in grant order.
REQ-026 Throughput: max one grant per port per 2 cycles; two ports together saturate the RAM.
REQ-027 Requester dropping req_i before gnt_o: request discarded, no side effect.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear gnt_o, rvalid_o, ram_en, ram_we, ram_re to 0, rdata_o, ram_addr_w, ram_addr_r, ram_d_w to 0, last_gnt to 1 (port 0 wins first contention).
REQ-029 Reset during an outstanding read SHALL cancel it: no rvalid_o after release.
REQ-030 First grant possible in the first cycle with rst_n=1; its pulse appears one cycle later.

Configuration
REQ-031 Macro RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins contention, last_gnt unused; port 1 may starve.
REQ-032 Macro RAM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-019 (default build).

Verification
REQ-033 Reset, no requests -> all outputs 0 for 10 cycles.
REQ-034 Port 0 writes addr 0..7 data 0..7 one at a time -> ram_we pulses with matching ram_addr_w/ram_d_w, gnt_o[0] every 2 cycles.
REQ-035 After REQ-034, both ports hold read requests (p0 addr 3, p1 addr 5) -> gnt p0 then p1 on consecutive cycles; rvalid_o[0] rdata=3, then rvalid_o[1] rdata=5.
REQ-036 Both ports hold continuous write requests 20 cycles -> grants alternate 0,1,0,1; ram_we high every cycle after first.
REQ-037 Read granted, rst_n pulled low before rvalid -> no rvalid_o after release; outputs reset immediately.
REQ-038 RAM_ARB_FIXED_PRIO_EN build, both ports continuously requesting -> only port 0 granted, port 1 granted only in cycles port 0 is masked.
